// File: rtl/mem_copy_dma.sv
// Word-by-word memory copy engine: one-cycle-latency source reads, ready-gated destination writes.
// Define MEM_COPY_CHECKSUM_EN to add a running checksum of accepted destination words.
module mem_copy_dma #(
    parameter int unsigned       DATA_W     = 32,
    parameter int unsigned       ADDR_W     = 32,
    parameter int unsigned       LEN_W      = 16,
    parameter bit                AUTO_START = 1'b1,
    parameter logic [ADDR_W-1:0] BOOT_SRC   = '0,
    parameter logic [ADDR_W-1:0] BOOT_DST   = '0,
    parameter int unsigned       BOOT_LEN   = 128
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] src_base,
    input  logic [ADDR_W-1:0] dst_base,
    input  logic [LEN_W-1:0]  len,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [DATA_W-1:0] rd_data,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data,
    input  logic              wr_ready,
    output logic              busy,
    output logic              done,
    output logic              mem_sel
`ifdef MEM_COPY_CHECKSUM_EN
    ,
    output logic [DATA_W-1:0] checksum
`endif
);

    localparam logic [ADDR_W-1:0] STEP = ADDR_W'(DATA_W / 8);

    typedef enum logic [1:0] {StIdle, StCopy, StDrain, StDone} state_e;

    state_e              state_q, state_d;
    logic                boot_q;
    logic [ADDR_W-1:0]   rd_addr_q, wr_addr_q;
    logic [LEN_W-1:0]    rd_left_q, wr_left_q;
    logic                rd_pend_q;
    logic                hb_valid_q, sk_valid_q;
    logic [DATA_W-1:0]   hb_data_q, sk_data_q;
    logic [ADDR_W-1:0]   hb_addr_q, sk_addr_q;

    logic                launch_boot, launch;
    logic [ADDR_W-1:0]   l_src, l_dst;
    logic [LEN_W-1:0]    l_len;
    logic                rd_fire, wr_fire;

    always_comb begin
        launch_boot = (state_q == StIdle) && boot_q;
        launch      = launch_boot || (start && (state_q == StIdle || state_q == StDone));
        l_src       = launch_boot ? BOOT_SRC : src_base;
        l_dst       = launch_boot ? BOOT_DST : dst_base;
        l_len       = launch_boot ? LEN_W'(BOOT_LEN) : len;
        wr_fire     = hb_valid_q && wr_ready;
        // A read is only issued when its data is guaranteed a slot (buffer or skid) next cycle.
        rd_fire     = (state_q == StCopy) && (rd_left_q != '0) && wr_ready && !sk_valid_q;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle, StDone: begin
                if (launch) state_d = (l_len == '0) ? StDone : StCopy;
            end
            StCopy: begin
                if (rd_fire && rd_left_q == LEN_W'(1)) state_d = StDrain;
            end
            StDrain: begin
                if (wr_fire && wr_left_q == LEN_W'(1)) state_d = StDone;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            boot_q     <= AUTO_START;
            rd_addr_q  <= '0;
            wr_addr_q  <= '0;
            rd_left_q  <= '0;
            wr_left_q  <= '0;
            rd_pend_q  <= 1'b0;
            hb_valid_q <= 1'b0;
            hb_data_q  <= '0;
            hb_addr_q  <= '0;
            sk_valid_q <= 1'b0;
            sk_data_q  <= '0;
            sk_addr_q  <= '0;
        end else if (launch) begin
            boot_q     <= 1'b0;
            rd_addr_q  <= l_src;
            wr_addr_q  <= l_dst;
            rd_left_q  <= l_len;
            wr_left_q  <= l_len;
            rd_pend_q  <= 1'b0;
            hb_valid_q <= 1'b0;
            sk_valid_q <= 1'b0;
        end else begin
            rd_pend_q <= rd_fire;
            if (rd_fire) begin
                rd_addr_q <= rd_addr_q + STEP;
                rd_left_q <= rd_left_q - LEN_W'(1);
            end
            if (wr_fire) wr_left_q <= wr_left_q - LEN_W'(1);
            // Skid slot refills the buffer first; returning read data lands wherever there is room.
            if (sk_valid_q) begin
                if (wr_fire) begin
                    hb_data_q  <= sk_data_q;
                    hb_addr_q  <= sk_addr_q;
                    sk_valid_q <= 1'b0;
                end
            end else if (rd_pend_q) begin
                if (!hb_valid_q || wr_fire) begin
                    hb_valid_q <= 1'b1;
                    hb_data_q  <= rd_data;
                    hb_addr_q  <= wr_addr_q;
                end else begin
                    sk_valid_q <= 1'b1;
                    sk_data_q  <= rd_data;
                    sk_addr_q  <= wr_addr_q;
                end
                wr_addr_q <= wr_addr_q + STEP;
            end else if (wr_fire) begin
                hb_valid_q <= 1'b0;
            end
        end
    end

`ifdef MEM_COPY_CHECKSUM_EN
    logic [DATA_W-1:0] checksum_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            checksum_q <= '0;
        end else if (launch) begin
            checksum_q <= '0;
        end else if (wr_fire) begin
            checksum_q <= checksum_q + hb_data_q;
        end
    end

    assign checksum = checksum_q;
`endif

    assign rd_en   = rd_fire;
    assign rd_addr = rd_addr_q;
    assign wr_en   = hb_valid_q;
    assign wr_addr = hb_addr_q;
    assign wr_data = hb_data_q;
    assign busy    = (state_q == StCopy) || (state_q == StDrain);
    assign done    = (state_q == StDone);
    assign mem_sel = (state_q == StDone);

endmodule

// File: tb/tb_mem_copy_dma.sv
// Directed bench for mem_copy_dma: boot copy, stalls, zero length, address wrap, reset abort.
// Checks the checksum port too when MEM_COPY_CHECKSUM_EN is defined.
module tb_mem_copy_dma;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [31:0] src_base, dst_base;
    logic [15:0] len;
    logic        rd_en;
    logic [31:0] rd_addr;
    logic [31:0] rd_data = '0;
    logic        wr_en;
    logic [31:0] wr_addr, wr_data;
    logic        wr_ready;
    logic        busy, done, mem_sel;
`ifdef MEM_COPY_CHECKSUM_EN
    logic [31:0] checksum;
`endif

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int rd_cnt = 0;
    logic [31:0] wa_q[$];
    logic [31:0] wd_q[$];
    int          wc_q[$];

    mem_copy_dma #(
        .AUTO_START(1'b1),
        .BOOT_LEN  (4)
    ) dut (
`ifdef MEM_COPY_CHECKSUM_EN
        .checksum(checksum),
`endif
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .src_base(src_base),
        .dst_base(dst_base),
        .len     (len),
        .rd_en   (rd_en),
        .rd_addr (rd_addr),
        .rd_data (rd_data),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .wr_ready(wr_ready),
        .busy    (busy),
        .done    (done),
        .mem_sel (mem_sel)
    );

    always #5 clk = ~clk;

    // Source ROM: word at byte address A holds (A/4)+1, returned one cycle after the read.
    always @(posedge clk) begin
        if (rd_en) rd_data <= (rd_addr >> 2) + 32'd1;
    end

    always @(posedge clk) begin
        cyc++;
        if (rst_n && rd_en) rd_cnt++;
        if (rst_n && wr_en && wr_ready) begin
            wa_q.push_back(wr_addr);
            wd_q.push_back(wr_data);
            wc_q.push_back(cyc);
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clear_log();
        wa_q.delete();
        wd_q.delete();
        wc_q.delete();
        rd_cnt = 0;
    endtask

    task automatic launch(input logic [31:0] s, input logic [31:0] d, input logic [15:0] n);
        @(negedge clk);
        start    = 1'b1;
        src_base = s;
        dst_base = d;
        len      = n;
        @(negedge clk);
        start = 1'b0;
        #1;
    endtask

    task automatic wait_done(input string tag);
        int n = 0;
        while (done !== 1'b1 && n < 100) begin
            @(negedge clk);
            #1;
            n++;
        end
        check(tag, done, 1'b1);
    endtask

    initial begin
        rst_n    = 1'b0;
        start    = 1'b0;
        src_base = '0;
        dst_base = '0;
        len      = '0;
        wr_ready = 1'b1;

        // Reset state
        repeat (2) @(negedge clk);
        #1;
        check("rst_rd_en", rd_en, 1'b0);
        check("rst_wr_en", wr_en, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_mem_sel", mem_sel, 1'b0);
        clear_log();
        rst_n = 1'b1;

        // Boot copy: 4 words from 0 to 0
        @(negedge clk);
        #1;
        check("boot_busy", busy, 1'b1);
        check("boot_mem_sel", mem_sel, 1'b0);
        check("boot_rd_en", rd_en, 1'b1);
        check("boot_rd_addr", rd_addr, 32'h0);
        repeat (2) @(negedge clk);
        #1;
        check("boot_first_wr_en", wr_en, 1'b1);
        check("boot_first_wr_addr", wr_addr, 32'h0);
        check("boot_first_wr_data", wr_data, 32'h1);
        wait_done("boot_done");
        check("boot_mem_sel_done", mem_sel, 1'b1);
        check("boot_busy_done", busy, 1'b0);
        check("boot_wr_cnt", wa_q.size(), 4);
        check("boot_wr_addr3", wa_q[3], 32'hC);
        check("boot_wr_data3", wd_q[3], 32'h4);
        check("boot_back_to_back", wc_q[3] - wc_q[0], 3);
`ifdef MEM_COPY_CHECKSUM_EN
        check("boot_checksum", checksum, 32'd10);
`endif

        // Stall: len 3, src 0x100, dst 0x200, wr_ready low while the first write is pending
        clear_log();
        launch(32'h100, 32'h200, 16'd3);
        check("stall_done_cleared", done, 1'b0);
        repeat (2) @(negedge clk);
        wr_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("stall_wr_en", wr_en, 1'b1);
            check("stall_wr_addr", wr_addr, 32'h200);
            check("stall_no_rd", rd_en, 1'b0);
            @(negedge clk);
        end
        wr_ready = 1'b1;
        #1;
        wait_done("stall_done");
        check("stall_wr_cnt", wa_q.size(), 3);
        check("stall_rd_cnt", rd_cnt, 3);
        check("stall_wr_addr0", wa_q[0], 32'h200);
        check("stall_wr_addr2", wa_q[2], 32'h208);
        check("stall_wr_data0", wd_q[0], 32'h41);
        check("stall_wr_data2", wd_q[2], 32'h43);
`ifdef MEM_COPY_CHECKSUM_EN
        check("stall_checksum", checksum, 32'hC6);
`endif

        // Zero length
        clear_log();
        launch(32'h0, 32'h0, 16'd0);
        check("zero_done", done, 1'b1);
        check("zero_busy", busy, 1'b0);
        repeat (3) @(negedge clk);
        #1;
        check("zero_rd_cnt", rd_cnt, 0);
        check("zero_wr_cnt", wa_q.size(), 0);

        // Start pulsed mid-copy is ignored
        clear_log();
        launch(32'h0, 32'h300, 16'd5);
        @(negedge clk);
        start    = 1'b1;
        src_base = 32'h500;
        dst_base = 32'h600;
        len      = 16'd9;
        @(negedge clk);
        start = 1'b0;
        #1;
        wait_done("ignore_done");
        check("ignore_wr_cnt", wa_q.size(), 5);
        check("ignore_rd_cnt", rd_cnt, 5);
        check("ignore_wr_addr0", wa_q[0], 32'h300);
        check("ignore_wr_addr4", wa_q[4], 32'h310);

        // Relaunch from DONE with destination address wrap
        clear_log();
        launch(32'h10, 32'hFFFF_FFFC, 16'd2);
        check("wrap_busy", busy, 1'b1);
        wait_done("wrap_done");
        check("wrap_wr_cnt", wa_q.size(), 2);
        check("wrap_wr_addr0", wa_q[0], 32'hFFFF_FFFC);
        check("wrap_wr_addr1", wa_q[1], 32'h0);
        check("wrap_wr_data1", wd_q[1], 32'h6);

        // Reset after 2 of 8 writes, then boot copy restarts
        clear_log();
        launch(32'h0, 32'h400, 16'd8);
        begin
            int n = 0;
            while (wa_q.size() < 2 && n < 50) begin
                @(negedge clk);
                #1;
                n++;
            end
        end
        check("abort_two_writes", wa_q.size(), 2);
        rst_n = 1'b0;
        #1;
        check("abort_rd_en", rd_en, 1'b0);
        check("abort_wr_en", wr_en, 1'b0);
        check("abort_busy", busy, 1'b0);
        check("abort_done", done, 1'b0);
        check("abort_mem_sel", mem_sel, 1'b0);
        check("abort_wr_addr", wr_addr, 32'h0);
        check("abort_rd_addr", rd_addr, 32'h0);
        @(negedge clk);
        clear_log();
        rst_n = 1'b1;
        #1;
        wait_done("reboot_done");
        check("reboot_wr_cnt", wa_q.size(), 4);
        check("reboot_wr_addr0", wa_q[0], 32'h0);
        check("reboot_wr_data0", wd_q[0], 32'h1);
        check("reboot_wr_addr3", wa_q[3], 32'hC);
        check("reboot_wr_data3", wd_q[3], 32'h4);
`ifdef MEM_COPY_CHECKSUM_EN
        check("reboot_checksum", checksum, 32'd10);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected finish");
        $fatal(1);
    end

endmodule
